// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative signed multiply/divide unit for the MIPS datapath (MULT / DIV).
//   Multiply uses radix-2 Booth, one step per cycle. Divide is restoring
//   division on operand magnitudes, one quotient bit per cycle. Signs are
//   fixed up in FINISH using truncating semantics: the quotient sign is
//   sign(A)^sign(B) and the remainder takes the sign of the dividend.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   A, B       signed operands (multiplicand/multiplier or dividend/divisor)
//   MultStart  request multiply (sampled only in IDLE, wins over DivStart)
//   DivStart   request divide  (sampled only in IDLE)
//   Hi, Lo     product high/low, or remainder/quotient
//   Busy       operation in progress (MULT, DIV, FINISH)
//   Done       one-cycle pulse when Hi/Lo are updated or a divide is rejected
//   DivZero    one-cycle pulse with Done when a divide by zero is rejected
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for MultStart/DivStart; rejects a divide by zero
// MULT   | one Booth step per cycle, ITER steps
// DIV    | one restoring-division step per cycle, ITER steps
// FINISH | sign fix-up, write Hi/Lo, pulse Done
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MultStart,
    input  logic             DivStart,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] count;
    // acc_hi carries one extra sign bit so that adding or subtracting a
    // multiplicand of -2^(WIDTH-1) cannot overflow during Booth steps.
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             booth_bit;
    logic [WIDTH-1:0] opnd;
    logic             sign_a;
    logic             sign_b;
    logic             op_div;

    logic             last_step;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   mult_hi_next;
    logic [WIDTH-1:0] mult_lo_next;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH:0]   div_hi_next;
    logic [WIDTH-1:0] div_lo_next;
    logic [WIDTH-1:0] rem_mag;

    assign last_step = (count == CNT_W'(ITER - 1));
    assign abs_a     = A[WIDTH-1] ? -A : A;
    assign abs_b     = B[WIDTH-1] ? -B : B;
    assign rem_mag   = acc_hi[WIDTH-1:0];

    // Booth step: examine {lsb of multiplier, previous lsb}, add/subtract the
    // sign-extended multiplicand, then arithmetic-shift the whole accumulator.
    always_comb begin
        booth_sum = acc_hi;
        case ({acc_lo[0], booth_bit})
            2'b01:   booth_sum = acc_hi + {opnd[WIDTH-1], opnd};
            2'b10:   booth_sum = acc_hi - {opnd[WIDTH-1], opnd};
            default: booth_sum = acc_hi;
        endcase
        mult_hi_next = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mult_lo_next = {booth_sum[0], acc_lo[WIDTH-1:1]};
    end

    // Restoring division step: shift the next dividend bit into the partial
    // remainder, subtract the divisor when it fits, record the quotient bit.
    always_comb begin
        div_shift   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, opnd});
        div_hi_next = div_ge ? (div_shift - {1'b0, opnd}) : div_shift;
        div_lo_next = {acc_lo[WIDTH-2:0], div_ge};
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (MultStart)                      state_next = MULT;
                else if (DivStart && (B != '0))     state_next = DIV;
            end
            MULT:    if (last_step) state_next = FINISH;
            DIV:     if (last_step) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy = (state != IDLE);
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            booth_bit <= 1'b0;
            opnd      <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            op_div    <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            Done      <= 1'b0;
            DivZero   <= 1'b0;
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (MultStart) begin
                        acc_hi    <= '0;
                        acc_lo    <= B;
                        booth_bit <= 1'b0;
                        opnd      <= A;
                        count     <= '0;
                        op_div    <= 1'b0;
                    end else if (DivStart) begin
                        if (B != '0) begin
                            acc_hi    <= '0;
                            acc_lo    <= abs_a;
                            booth_bit <= 1'b0;
                            opnd      <= abs_b;
                            sign_a    <= A[WIDTH-1];
                            sign_b    <= B[WIDTH-1];
                            count     <= '0;
                            op_div    <= 1'b1;
                        end else begin
                            Done    <= 1'b1;
                            DivZero <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc_hi    <= mult_hi_next;
                    acc_lo    <= mult_lo_next;
                    booth_bit <= acc_lo[0];
                    count     <= count + CNT_W'(1);
                end
                DIV: begin
                    acc_hi <= div_hi_next;
                    acc_lo <= div_lo_next;
                    count  <= count + CNT_W'(1);
                end
                FINISH: begin
                    if (op_div) begin
                        // -2^(W-1) / -1 wraps naturally to 0x80..0 here.
                        Lo <= (sign_a ^ sign_b) ? -acc_lo : acc_lo;
                        Hi <= sign_a ? -rem_mag : rem_mag;
                    end else begin
                        Hi <= acc_hi[WIDTH-1:0];
                        Lo <= acc_lo;
                    end
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] A, B;
    logic         MultStart, DivStart;
    logic [W-1:0] Hi, Lo;
    logic         Busy, Done, DivZero;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W), .ITER(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .MultStart (MultStart),
        .DivStart  (DivStart),
        .Hi        (Hi),
        .Lo        (Lo),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic. SV division truncates toward
    // zero and the remainder follows the dividend, matching MIPS.
    task automatic ref_model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    task automatic run_op(input bit do_mult, input bit do_div,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
        logic [W-1:0] eh, el;
        bit hold_ok;
        int cyc;
        hold_ok = 1'b1;
        cyc = 0;
        @(negedge clk);
        A = a; B = b; MultStart = do_mult; DivStart = do_div;
        @(negedge clk);
        MultStart = 1'b0; DivStart = 1'b0;
        A = $urandom; B = $urandom;
        if (!do_mult && b == '0) begin
            chk("dz_done", Done, 1);
            chk("dz_flag", DivZero, 1);
            chk("dz_busy", Busy, 0);
            chk("dz_hilo", {Hi, Lo}, {exp_hi, exp_lo});
            @(negedge clk);
            chk("dz_pulse_end", {Done, DivZero}, 0);
            return;
        end
        ref_model(!do_mult, a, b, eh, el);
        chk("busy_start", Busy, 1);
        while (!Done && cyc < 40) begin
            if (Hi !== exp_hi || Lo !== exp_lo || Busy !== 1'b1) hold_ok = 1'b0;
            if (disturb && cyc == 5) begin
                DivStart = 1'b1; MultStart = 1'b1; A = '0; B = '0;
            end
            if (disturb && cyc == 6) begin
                DivStart = 1'b0; MultStart = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, 33);
        chk("hold_busy", hold_ok, 1);
        chk(do_mult ? "mult_hi" : "div_hi", Hi, eh);
        chk(do_mult ? "mult_lo" : "div_lo", Lo, el);
        chk("busy_at_done", Busy, 0);
        chk("divzero_at_done", DivZero, 0);
        exp_hi = eh;
        exp_lo = el;
        @(negedge clk);
        chk("done_pulse_end", Done, 0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corner [6];
        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h0000_0007;
        case ($urandom_range(0, 3))
            0:       return corner[$urandom_range(0, 5)];
            1:       return W'($urandom_range(0, 100));
            2:       return -W'($urandom_range(1, 100));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done_seen;
        logic [W-1:0] ra, rb;
        reset = 1'b0; A = '0; B = '0; MultStart = 1'b0; DivStart = 1'b0;
        #1;
        chk("reset_outputs", {Hi, Lo, Busy, Done, DivZero}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(0, 1, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1, 0, 32'd1234, 32'hFFFF_0005, 0);
        run_op(0, 1, 32'd55, 32'd0, 0);
        run_op(1, 1, 32'd9, 32'hFFFF_FFF8, 1);
        run_op(0, 1, 32'hFFFF_FF00, 32'd7, 1);

        // Reset in the middle of a multiply
        @(negedge clk);
        A = 32'd100; B = 32'd200; MultStart = 1'b1;
        @(negedge clk);
        MultStart = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_outputs", {Hi, Lo, Busy, Done, DivZero}, '0);
        exp_hi = '0; exp_lo = '0;
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (Done) done_seen = 1'b1;
        end
        chk("midreset_no_done", done_seen, 0);
        reset = 1'b1;
        done_seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (Done || Busy) done_seen = 1'b1;
        end
        chk("midreset_stays_idle", done_seen, 0);
        run_op(1, 0, 32'd3, 32'd5, 0);

        for (int i = 0; i < 40; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            case ($urandom_range(0, 3))
                0:       run_op(1, 0, ra, rb, $urandom_range(0, 1) == 1);
                1:       run_op(1, 1, ra, rb, 0);
                default: run_op(0, 1, ra, rb, $urandom_range(0, 1) == 1);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit for the MIPS datapath. Serves MULT and DIV.
- Consumes operand A from the A register and operand B from the B register, the same B that feeds the ALU operand-B mux.
- Produces the Hi/Lo pair that the Hi/Lo move paths read.
- Iterative, one bit per cycle, with a start/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand width; Hi and Lo are each WIDTH bits.
- ITER, WIDTH, iteration count per operation; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- A  input  WIDTH  signed operand: multiplicand, or dividend.
- B  input  WIDTH  signed operand: multiplier, or divisor.
- MultStart  input  1  request signed multiply, sampled only in IDLE.
- DivStart  input  1  request signed divide, sampled only in IDLE.
- Hi  output  WIDTH  upper product, or remainder.
- Lo  output  WIDTH  lower product, or quotient.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when Hi/Lo have been updated or a divide has been rejected.
- DivZero  output  1  one-cycle pulse together with Done when the divisor is 0.

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, Hi=0, Lo=0, Busy=0, Done=0, DivZero=0, internal regs=0.
- States: IDLE, MULT, DIV, FINISH.
- IDLE:
  - MultStart=1: latch A and B, go to MULT, counter=0.
  - DivStart=1 and B!=0: latch |A| and |B| plus both signs, go to DIV.
  - DivStart=1 and B=0: stay in IDLE. Pulse Done=1 and DivZero=1 on the next cycle. Hi/Lo unchanged.
  - Both starts high: MultStart wins; DivStart is ignored.
- MULT: radix-2 Booth, one step per cycle, 2*WIDTH-bit accumulator plus a Booth extra bit, arithmetic right shift. After ITER steps go to FINISH.
- DIV: restoring division on magnitudes, one quotient bit per cycle. After ITER steps go to FINISH.
- FINISH (one cycle):
  - Write Hi/Lo, pulse Done=1, go to IDLE.
  - Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A) (MIPS truncating semantics).
- Latency: start sampled at edge N. Busy=1 from N+1 through the state that ends at edge N+ITER+1. Hi/Lo written and Done=1 after edge N+ITER+1 (N+33 for WIDTH=32). Busy=0 in that same cycle.
- Busy=1 in MULT, DIV and FINISH. Done and DivZero are never high for more than one cycle.
- Start pulses while Busy=1 are ignored; no queuing.
- A and B may change after the start cycle; operands are latched.
- Hi/Lo hold their previous values throughout an operation. They are updated only in FINISH or by reset.
- Overflow case −2^(WIDTH−1) / −1: Lo=0x80000000, Hi=0 (wrap, no flag).
- Multiply never overflows; the full 64-bit signed product is returned.
- Reset asserted mid-operation: abort immediately, all outputs return to reset values, no Done pulse.
- Back-to-back operation: a new start is accepted in the cycle right after FINISH, since the state is then IDLE.

Test Plan:
- Reset then MultStart with A=7, B=0xFFFFFFFD (−3) -> after 33 edges Done=1 for one cycle, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Busy falls in the same cycle.
- MultStart with A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000. Then A=B=0xFFFFFFFF -> Hi=0, Lo=1.
- DivStart with A=0xFFFFFFF9 (−7), B=2 -> Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1). Then A=7, B=0xFFFFFFFE -> Lo=0xFFFFFFFD, Hi=1. Then A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DivStart with B=0 and Hi/Lo preloaded by a previous MULT -> Done=1 and DivZero=1 one cycle later, Busy stays 0, Hi/Lo unchanged.
- MultStart and DivStart both high -> multiply result. During Busy, pulse DivStart and change A/B -> ignored, result is unaffected.
- Drive reset=0 at cycle 10 of a MULT -> Hi=Lo=0 and Busy=0 immediately, no Done. After reset=1, a new MULT (A=3, B=5) gives Lo=15, Hi=0.
